// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master arbiter in front of a single data-memory port. m0 is the core,
//   m1 an external loader/debug master. Ownership is held while the owner keeps
//   requesting. When the other master is also waiting, the owner is limited to
//   MAX_BURST consecutive grants. Grants are combinational within the owned
//   state, so the memory sees the request in the same cycle it is granted.
//
// Parameters
//   MAX_BURST    (1..15) max back-to-back grants while the other master waits
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   mX_req/addr/we/wd           master X request, address, write enable, data
//   mX_gnt                      access performed for master X this cycle
//   mX_rdata                    mem_rd when granted, else 0
//   mem_addr/mem_we/mem_wd      RAM port (clocked write)
//   mem_rd                      RAM combinational read data
//   conflict_cnt                cycles with a request left waiting
//
// Build option
//   DMEM_ARBITER_STATS_EN       when defined, conflict_cnt is a live counter;
//                               otherwise it is tied to 0 and no counter exists.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic        m0_we,
   input  logic [31:0] m0_wd,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_we,
   input  logic [31:0] m1_wd,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic [31:0] conflict_cnt
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   state_t      state_q, state_d;
   logic        last_owner_q, last_owner_d;
   logic [3:0]  burst_cnt_q, burst_cnt_d;

   // Grants and memory mux. Reset gates everything so nothing reaches the RAM
   // while rst is high, even if the state register still holds an owner.
   always_comb begin
      m0_gnt   = ~rst & (state_q == OWN0) & m0_req;
      m1_gnt   = ~rst & (state_q == OWN1) & m1_req;
      mem_addr = '0;
      mem_wd   = '0;
      mem_we   = 1'b0;
      if (m0_gnt) begin
         mem_addr = m0_addr;
         mem_wd   = m0_wd;
         mem_we   = m0_we;
      end else if (m1_gnt) begin
         mem_addr = m1_addr;
         mem_wd   = m1_wd;
         mem_we   = m1_we;
      end
      m0_rdata = m0_gnt ? mem_rd : '0;
      m1_rdata = m1_gnt ? mem_rd : '0;
   end

   // Next-state logic. The two owned states are symmetric, so they share one
   // branch expressed in terms of "current" and "other" master.
   logic   cur_req, oth_req, cur_id;
   state_t oth_state;

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      cur_id       = (state_q == OWN1);
      cur_req      = cur_id ? m1_req : m0_req;
      oth_req      = cur_id ? m0_req : m1_req;
      oth_state    = cur_id ? OWN0 : OWN1;

      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            // On a tie the master that did not own last goes first.
            if (m0_req && (!m1_req || last_owner_q))
               state_d = OWN0;
            else if (m1_req)
               state_d = OWN1;
         end
         OWN0, OWN1: begin
            if (!cur_req) begin
               last_owner_d = cur_id;
               burst_cnt_d  = '0;
               state_d      = oth_req ? oth_state : IDLE;
            end else if (oth_req && burst_cnt_q == BURST_LAST) begin
               last_owner_d = cur_id;
               burst_cnt_d  = '0;
               state_d      = oth_state;
            end else if (burst_cnt_q != BURST_LAST) begin
               // Saturating, so a waiter arriving late preempts immediately
               // once the owner has already used its full burst.
               burst_cnt_d = burst_cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

`ifdef DMEM_ARBITER_STATS_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q
                     + 32'((m0_req & ~m0_gnt) | (m1_req & ~m1_gnt));
   end

   always_ff @(posedge clk) begin
      if (rst) conflict_cnt_q <= '0;
      else     conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`else
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Scoreboard bench. A driver applies one cycle of inputs just after each
//   rising edge, predicts that cycle's outputs with a transaction-level model
//   (owner / run length / memory image) and queues the prediction. A monitor
//   samples the DUT on the falling edge and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
   logic        m0_gnt, m1_gnt, mem_we;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd, conflict_cnt;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .conflict_cnt(conflict_cnt)
   );

   // RAM attached to the DUT: combinational read, clocked write.
   logic [31:0] ram [0:255];
   assign mem_rd = ram[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wd;

   typedef struct packed {
      logic        g0, g1, we;
      logic [31:0] addr, wd, rd0, rd1, cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference model state.
   int          m_owner = -1;   // -1 none, else master index
   int          m_last  = 1;
   int          m_run   = 0;    // grants in the current tenure
   logic [31:0] m_cnt   = '0;
   logic [31:0] m_mem [0:255];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic rs);
      exp_t e;
      logic rq [2];
      int   x, y;
      @(posedge clk); #1;
      rst = rs;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wd = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wd = d1;
      rq[0] = r0; rq[1] = r1;
      e = '0;
      e.cnt = m_cnt;
      if (rs) begin
         m_owner = -1; m_last = 1; m_run = 0; m_cnt = '0;
      end else begin
         e.g0 = (m_owner == 0) && r0;
         e.g1 = (m_owner == 1) && r1;
         if (e.g0) begin
            e.addr = a0; e.wd = d0; e.we = w0; e.rd0 = m_mem[a0[9:2]];
            if (w0) m_mem[a0[9:2]] = d0;
         end
         if (e.g1) begin
            e.addr = a1; e.wd = d1; e.we = w1; e.rd1 = m_mem[a1[9:2]];
            if (w1) m_mem[a1[9:2]] = d1;
         end
         if ((r0 && !e.g0) || (r1 && !e.g1)) m_cnt = m_cnt + 32'd1;
         if (m_owner < 0) begin
            m_run = 0;
            if (r0 && r1) m_owner = (m_last == 1) ? 0 : 1;
            else if (r0)  m_owner = 0;
            else if (r1)  m_owner = 1;
         end else begin
            x = m_owner; y = 1 - x;
            if (!rq[x]) begin
               m_last = x; m_run = 0;
               m_owner = rq[y] ? y : -1;
            end else begin
               m_run++;
               if (rq[y] && m_run >= MAXB) begin
                  m_last = x; m_owner = y; m_run = 0;
               end
            end
         end
      end
`ifndef DMEM_ARBITER_STATS_EN
      e.cnt = '0;
`endif
      q.push_back(e);
   endtask

   task automatic idle_cyc(input logic rs);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, rs);
   endtask

   // Monitor: one comparison set per predicted cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("m0_gnt",   32'(m0_gnt),   32'(e.g0));
            chk("m1_gnt",   32'(m1_gnt),   32'(e.g1));
            chk("mem_we",   32'(mem_we),   32'(e.we));
            chk("mem_addr", mem_addr,      e.addr);
            chk("mem_wd",   mem_wd,        e.wd);
            chk("m0_rdata", m0_rdata,      e.rd0);
            chk("m1_rdata", m1_rdata,      e.rd1);
            chk("conflict_cnt", conflict_cnt, e.cnt);
         end
      end
   end

   initial begin
      int wait_cyc;
      for (int i = 0; i < 256; i++) begin
         ram[i] = '0;
         m_mem[i] = '0;
      end
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
      @(posedge clk);

      // Reset state.
      idle_cyc(1'b1);
      idle_cyc(1'b1);

      // Single m0 write, then read back.
      drive(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      drive(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      idle_cyc(1'b0);
      drive(1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);
      drive(1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);
      idle_cyc(1'b0);

      // Tie right after reset: m0 first, then bursts of MAXB alternate.
      idle_cyc(1'b1);
      for (int i = 0; i < 3 * MAXB + 1; i++)
         drive(1, 0, 32'h100, 32'h0, 1, 0, 32'h104, 32'h0, 0);
      idle_cyc(1'b0);
      idle_cyc(1'b0);

      // m1 alone for 20 cycles: no switch, counter saturates silently.
      for (int i = 0; i < 20; i++)
         drive(0, 0, 0, 0, 1, 1, 32'(32'h200 + 4 * i), $urandom, 0);
      idle_cyc(1'b0);

      // Reset in the 2nd grant cycle of an m1 write burst, then a tie.
      drive(0, 0, 0, 0, 1, 1, 32'h300, 32'h11111111, 0);
      drive(0, 0, 0, 0, 1, 1, 32'h304, 32'h22222222, 0);
      drive(0, 0, 0, 0, 1, 1, 32'h308, 32'h33333333, 1);
      for (int i = 0; i < 4; i++)
         drive(1, 0, 32'h308, 0, 1, 0, 32'h304, 0, 0);
      idle_cyc(1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
               {22'h0, 8'($urandom), 2'b00}, $urandom,
               $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
               {22'h0, 8'($urandom), 2'b00}, $urandom,
               $urandom_range(0, 59) == 0);
      end

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      if (q.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
